// File: rtl/mem_arbiter_if.sv
// Bundles the CPU-side fetch/data request ports and the shared RAM port
// of the memory arbiter. The arbiter uses the slave view; the
// environment (CPU side plus RAM) uses the master view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data access for the single shared
// RAM port. Data is favoured, but after STARVE_LIMIT consecutive data
// completions with a fetch pending, the fetch is granted next. A grant is
// held until RAM reports ACCESS/ERROR or the requester withdraws.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DGNT = 2'd1;
    localparam logic [1:0] IGNT = 2'd2;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [3:0] starve_cnt;
    logic       dreq;
    logic       ram_done;
    logic       d_done;
    logic       i_done;

    assign dreq     = bus.dREN | bus.dWEN;
    assign ram_done = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
    assign d_done   = (state == DGNT) && dreq && ram_done;
    assign i_done   = (state == IGNT) && bus.iREN && ram_done;

    // Grant selection in IDLE; a grant ends on completion or withdrawal.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq && (!bus.iREN || starve_cnt < LIMIT))
                    next_state = DGNT;
                else if (bus.iREN)
                    next_state = IGNT;
            end
            DGNT: begin
                if (!dreq || ram_done)
                    next_state = IDLE;
            end
            IGNT: begin
                if (!bus.iREN || ram_done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Counts data completions that overtook a pending fetch, saturating.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt <= '0;
        else if (!bus.iREN || i_done)
            starve_cnt <= '0;
        else if (d_done && starve_cnt < LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // RAM strobes and CPU-side handshakes follow the grant combinationally,
    // so a withdrawn request drops the strobes in the same cycle.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramerr   = 1'b0;
        if (state == DGNT && dreq) begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            if (d_done) begin
                bus.dwait  = 1'b0;
                bus.dload  = bus.ramload;
                bus.ramerr = (bus.ramstate == RS_ERROR);
            end
        end else if (state == IGNT && bus.iREN) begin
            bus.ramaddr = bus.iaddr;
            bus.ramREN  = 1'b1;
            if (i_done) begin
                bus.iwait  = 1'b0;
                bus.iload  = bus.ramload;
                bus.ramerr = (bus.ramstate == RS_ERROR);
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver applies one cycle of
// stimulus per falling edge, runs a transaction-level owner/fairness model
// and queues the expected RAM/CPU response for every cycle in which
// something should be visible; an independent monitor compares whatever
// the DUT presents against the queue.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic CLK;
    logic nRST;
    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        longint       t;
        logic [132:0] v;
        logic [132:0] m;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who holds the RAM (0 none, 1 data, 2 fetch) and how
    // many data accesses in a row have overtaken a waiting fetch.
    int owner = 0;
    int overtaken = 0;

    task automatic chk(input string name, input logic [132:0] act,
                       input logic [132:0] exp, input logic [132:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act & mask, exp & mask);
        end
    endtask

    function automatic logic [132:0] dut_vec();
        return {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramerr,
                bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
    endfunction

    task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] ds, input logic [1:0] rs,
                         input logic [31:0] rl);
        logic        e_ren, e_wen, e_iw, e_dw, e_err, done, dreq;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        logic [132:0] mask;
        int nxt;
        exp_t e;
        @(negedge CLK);
        nRST = rst;
        bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;
        if (!rst) begin
            owner = 0;
            overtaken = 0;
            return;
        end
        e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_err = 0;
        e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
        mask = '1;
        dreq = dr | dw;
        done = (rs == 2'd2) || (rs == 2'd3);
        nxt = owner;
        if (owner == 0) begin
            if (dreq && (!ir || overtaken < LIMIT)) nxt = 1;
            else if (ir) nxt = 2;
        end else if (owner == 1) begin
            if (dreq) begin
                e_addr = da; e_store = ds; e_wen = dw; e_ren = dr && !dw;
                if (done) begin
                    e_dw = 0; e_dl = rl; e_err = (rs == 2'd3); nxt = 0;
                    if (ir && overtaken < LIMIT) overtaken++;
                end
            end else nxt = 0;
        end else begin
            if (ir) begin
                e_addr = ia; e_ren = 1;
                if (done) begin
                    e_iw = 0; e_il = rl; e_err = (rs == 2'd3); nxt = 0;
                    overtaken = 0;
                end
            end else nxt = 0;
        end
        if (!ir) overtaken = 0;
        owner = nxt;
        if (e_err) mask[63:0] = '0;
        if (e_ren || e_wen || !e_iw || !e_dw || e_err) begin
            e.t = $time;
            e.v = {e_ren, e_wen, e_iw, e_dw, e_err, e_addr, e_store, e_il, e_dl};
            e.m = mask;
            q.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    // Monitor: compares every cycle in which the DUT shows activity.
    initial begin
        exp_t   e;
        longint t;
        logic [132:0] act;
        forever begin
            @(negedge CLK);
            #2;
            t = $time - 2;
            act = dut_vec();
            while (q.size() > 0 && q[0].t < t) begin
                e = q.pop_front();
                chk("missed_response", '0, e.v, '1);
            end
            if (act[132] || act[131] || !act[130] || !act[129] || act[128]) begin
                if (q.size() == 0 || q[0].t != t) begin
                    chk("unexpected_activity", act, {2'b00, 2'b11, 1'b0, 128'd0}, '1);
                end else begin
                    e = q.pop_front();
                    chk("response", act, e.v, e.m);
                end
            end
        end
    end

    initial begin
        logic ir, dr, dw;
        // Reset with both requests raised: everything idle.
        nRST = 1'b0;
        bus.iREN = 1; bus.iaddr = 32'h40; bus.dREN = 1; bus.dWEN = 0;
        bus.daddr = 32'h100; bus.dstore = 0; bus.ramstate = 2'd0; bus.ramload = 0;
        #1;
        chk("reset_outputs", dut_vec(), {2'b00, 2'b11, 1'b0, 128'd0}, '1);
        #5;
        chk("reset_held_over_edge", dut_vec(), {2'b00, 2'b11, 1'b0, 128'd0}, '1);

        // Simultaneous requests: data first, then the fetch.
        drive(1, 1, 32'h40, 1, 0, 32'h100, 0, 2'd0, 0);
        drive(1, 1, 32'h40, 1, 0, 32'h100, 0, 2'd2, 32'hDEAD0001);
        drive(1, 1, 32'h40, 0, 0, 32'h100, 0, 2'd0, 0);
        drive(1, 1, 32'h40, 0, 0, 32'h100, 0, 2'd2, 32'hCAFE0002);
        idle_cycle();

        // Single fetch with two BUSY cycles.
        drive(1, 1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
        drive(1, 1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        drive(1, 1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        drive(1, 1, 32'h40, 0, 0, 0, 0, 2'd2, 32'h8C010004);
        idle_cycle();

        // Starvation bound: fetch and writes held continuously.
        for (int i = 0; i < 24; i++)
            drive(1, 1, 32'h80, 0, 1, 32'h200 + 32'(i), 32'h1000 + 32'(i), 2'd2, 32'h55AA0000 + 32'(i));
        idle_cycle();

        // Abort of a data read while RAM is busy.
        drive(1, 0, 0, 1, 0, 32'h300, 0, 2'd1, 0);
        drive(1, 0, 0, 1, 0, 32'h300, 0, 2'd1, 0);
        drive(1, 0, 0, 0, 0, 32'h300, 0, 2'd1, 0);
        idle_cycle();

        // Fetch ending in ERROR.
        drive(1, 1, 32'h44, 0, 0, 0, 0, 2'd0, 0);
        drive(1, 1, 32'h44, 0, 0, 0, 0, 2'd3, 32'h0BAD0BAD);
        idle_cycle();

        // Asynchronous reset in the middle of a data grant.
        drive(1, 0, 0, 1, 0, 32'h400, 0, 2'd1, 0);
        drive(1, 0, 0, 1, 0, 32'h400, 0, 2'd1, 0);
        #3;
        nRST = 1'b0;
        #1;
        chk("async_reset_mid_grant", dut_vec(), {2'b00, 2'b11, 1'b0, 128'd0}, '1);
        drive(0, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        idle_cycle();

        // Randomized traffic with sticky requests.
        ir = 0; dr = 0; dw = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ir = ~ir;
            if ($urandom_range(0, 7) == 0) dr = ~dr;
            if ($urandom_range(0, 9) == 0) dw = ~dw;
            drive(1, ir, $urandom, dr, dw, $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom);
        end
        repeat (3) idle_cycle();
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter between the instruction-fetch port and the data-memory port of the pipelined CPU for the single shared RAM port. It grants one requester at a time, holds the grant until RAM reports completion, and favours data accesses while bounding instruction-fetch starvation. Its `iwait`/`dwait` outputs feed the hazard unit's stall logic and the datapath enables.

## Interface
Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- ramstate  in  2  RAM status (ramstate_t): FREE=0, BUSY=1, ACCESS=2, ERROR=3
- ramload  in  32  RAM read data
- iwait  out  1  fetch not complete this cycle
- dwait  out  1  data access not complete this cycle
- iload  out  32  fetch data
- dload  out  32  data read result
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramerr  out  1  one-cycle pulse when the granted access ends in ERROR

## Operation
- FSM states:
  - IDLE: no grant. All RAM strobes are 0.
  - DGNT: data grant.
  - IGNT: instruction grant.
- Arbitration is evaluated only in IDLE. Let `dreq = dREN | dWEN`.
  - `dreq & (!iREN | starve_cnt < STARVE_LIMIT)` → DGNT.
  - Otherwise `iREN` → IGNT.
  - Otherwise stay in IDLE.
- DGNT drives RAM combinationally:
  - ramaddr = daddr, ramstore = dstore.
  - ramWEN = dWEN.
  - ramREN = dREN & !dWEN. Write wins when both are asserted.
- IGNT drives ramaddr = iaddr, ramREN = 1, ramWEN = 0, ramstore = 0.
- Completion occurs when the granted requester is still asserting its request and ramstate is ACCESS or ERROR.
  - Granted wait output goes to 0 for exactly that cycle.
  - Granted load output = ramload.
  - FSM returns to IDLE on the next edge.
  - On ERROR, ramerr = 1 for that cycle. Load data is don't-care.
- FREE or BUSY while granted: hold the grant, keep the wait output at 1, keep the RAM signals stable.
- Abort: if the granted requester deasserts its request while granted, the FSM returns to IDLE on the next edge with no completion. RAM strobes drop combinationally in that same cycle.
- The non-granted wait output is always 1. Both wait outputs are 1 in IDLE. Load outputs are 0 when not completing.
- Starvation counter `starve_cnt`:
  - Width 4, saturating at STARVE_LIMIT.
  - On a data completion while iREN = 1: increments.
  - On an instruction completion, or any cycle with iREN = 0: cleared to 0.
  - Otherwise holds.

## Timing
- Reset, asynchronous and immediate:
  - state = IDLE, starve_cnt = 0.
  - iwait = dwait = 1, ramREN = ramWEN = 0, ramaddr = ramstore = 0, iload = dload = 0, ramerr = 0.
- Reset asserted mid-grant aborts the access. Strobes drop without waiting for a clock.
- Latency: a request first seen in IDLE at cycle N is granted at N+1, with RAM strobes driven from N+1. If ramstate = ACCESS at N+1, wait drops at N+1.
- Minimum back-to-back spacing is 2 cycles per access: grant cycle plus one IDLE cycle.
- All outputs are Moore in state plus combinational on ramstate, requests and addresses. There are no registered outputs besides the state and the counter.
- Requests that arrive during the other requester's grant wait. They are evaluated in the following IDLE cycle.

## Test plan
- Reset: nRST = 0 with dREN = iREN = 1 → iwait = dwait = 1, ramREN = ramWEN = 0, ramaddr = 0. Release, next edge → DGNT, ramaddr = daddr.
- Single fetch: iREN = 1, iaddr = 0x40, ramstate BUSY×2 then ACCESS, ramload = 0x8C010004 → ramREN high for 3 cycles, iwait = 0 only on the ACCESS cycle, iload = 0x8C010004, then IDLE.
- Simultaneous: iREN = dREN = 1, daddr = 0x100, 1-cycle ACCESS → data completes first; next grant is IGNT with ramaddr = iaddr.
- Starvation, STARVE_LIMIT = 4: iREN and dWEN held continuously → exactly 4 data writes with ramWEN = 1, then one fetch, then data again. starve_cnt sequence is 1, 2, 3, 4, 0.
- Abort: DGNT with ramstate BUSY, dREN drops → ramREN = 0 in the same cycle, dwait stays 1, FSM back in IDLE next edge.
- Error: IGNT with ramstate = ERROR → ramerr pulses for 1 cycle, iwait = 0 that cycle, FSM returns to IDLE.
